// File: rtl/mrx_pkg.sv
// Shared definitions for the multi-tone receive controller.
//   mrx_state_e   : frame FSM states
//   clog2         : elaboration-time ceil(log2) helper
//   acc_min_width : smallest accumulator that cannot overflow over one symbol
package mrx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitHop,
    StAccum,
    StDecide
  } mrx_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Product is 2*dw+1 bits; summing nsig of them needs clog2(nsig) more.
  function automatic int unsigned acc_min_width(input int unsigned dw, input int unsigned nsig);
    return 2 * dw + 1 + clog2(nsig);
  endfunction

endpackage

// File: rtl/mrx_sym_acc.sv
// Two-stage coherent correlator for one symbol.
//   Stage 1 registers p = i*cos + q*sin when valid_i is high.
//   Stage 2 adds the sign-extended p into the accumulator when stage 1 holds a sample.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   valid_i            sample accepted this cycle
//   clr_i              zero the accumulator and drop any sample in stage 1
//   i_i, q_i           received baseband (signed)
//   cos_i, sin_i       local NCO reference (signed)
//   acc_o              running symbol correlation (signed)
//   vld_o              stage-1 holds a product that is folded in at the next edge
module mrx_sym_acc #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 48
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] i_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] cos_i,
  input  logic [DATA_WIDTH-1:0] sin_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  vld_o
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned PW    = ProdW + 1;

  logic signed [ProdW-1:0]     prod_i, prod_q;
  logic        [PW-1:0]        p_d, p_q;
  logic                        vld_q;
  logic        [ACC_WIDTH-1:0] acc_q, p_ext;

  always_comb begin
    prod_i = ProdW'($signed(i_i)) * ProdW'($signed(cos_i));
    prod_q = ProdW'($signed(q_i)) * ProdW'($signed(sin_i));
    p_d    = {prod_i[ProdW-1], prod_i} + {prod_q[ProdW-1], prod_q};
    p_ext  = {{(ACC_WIDTH - PW){p_q[PW-1]}}, p_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q   <= '0;
      vld_q <= 1'b0;
      acc_q <= '0;
    end else if (clr_i) begin
      vld_q <= 1'b0;
      acc_q <= '0;
    end else begin
      vld_q <= valid_i;
      if (valid_i) p_q <= p_d;
      if (vld_q) acc_q <= acc_q + p_ext;
    end
  end

  assign acc_o = acc_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/mrx_ctrl.sv
// Receive controller: hop-aligned BPSK bit recovery into a frame register.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   irx, qrx, rx_valid   received baseband samples and qualifier
//   cos_ref, sin_ref     NCO reference aligned with irx/qrx
//   hop_clk              hop strobe, asynchronous to clk
//   rx_trig, rx_nbits    frame start and length (0 or >RX_BITS_WIDTH means full width)
//   rx_bits              decided bits, LSB first
//   nrx_bits_cnt         index of the next bit to write
//   bit_valid, bit_out   one-cycle decision strobe and value
//   frame_done, busy     end-of-frame pulse, frame in progress
//   hop_err              sticky: hop edge landed inside a symbol
//   symbN, sigN          symbol index within hop, sample index within symbol
module mrx_ctrl
  import mrx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned NSIG          = 512,
  parameter int unsigned NSYMB         = 4,
  parameter int unsigned ACC_WIDTH     = 48,
  parameter int unsigned RX_BITS_WIDTH = 128,
  parameter int unsigned BIT_CNT_WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    irx,
  input  logic [DATA_WIDTH-1:0]    qrx,
  input  logic                     rx_valid,
  input  logic [DATA_WIDTH-1:0]    cos_ref,
  input  logic [DATA_WIDTH-1:0]    sin_ref,
  input  logic                     hop_clk,
  input  logic                     rx_trig,
  input  logic [BIT_CNT_WIDTH:0]   rx_nbits,
  output logic [RX_BITS_WIDTH-1:0] rx_bits,
  output logic [BIT_CNT_WIDTH-1:0] nrx_bits_cnt,
  output logic                     bit_valid,
  output logic                     bit_out,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     hop_err,
  output logic [15:0]              symbN,
  output logic [clog2(NSIG)-1:0]   sigN
);

  localparam int unsigned SigW = clog2(NSIG);
  localparam logic [SigW-1:0]          SigLast  = SigW'(NSIG - 1);
  localparam logic [15:0]              SymbLast = 16'(NSYMB - 1);
  localparam logic [BIT_CNT_WIDTH:0]   NbitsMax = (BIT_CNT_WIDTH + 1)'(RX_BITS_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0] AccZero = '0;

  if (ACC_WIDTH < acc_min_width(DATA_WIDTH, NSIG)) begin : gen_acc_width_bad
    $error("mrx_ctrl: ACC_WIDTH too small for DATA_WIDTH/NSIG");
  end

  // Hop strobe: two-flop synchronizer, then registered rising-edge detect.
  logic hop_s1_q, hop_s2_q, hop_s3_q, hop_edge_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hop_s1_q   <= 1'b0;
      hop_s2_q   <= 1'b0;
      hop_s3_q   <= 1'b0;
      hop_edge_q <= 1'b0;
    end else begin
      hop_s1_q   <= hop_clk;
      hop_s2_q   <= hop_s1_q;
      hop_s3_q   <= hop_s2_q;
      hop_edge_q <= hop_s2_q & ~hop_s3_q;
    end
  end

  logic                        accept, acc_clr, acc_vld, acc_nonneg;
  logic signed [ACC_WIDTH-1:0] acc;

  mrx_sym_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sym_acc (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (accept),
    .clr_i   (acc_clr),
    .i_i     (irx),
    .q_i     (qrx),
    .cos_i   (cos_ref),
    .sin_i   (sin_ref),
    .acc_o   (acc),
    .vld_o   (acc_vld)
  );

  assign acc_nonneg = (acc >= AccZero);

  mrx_state_e                 state_q, state_d;
  logic [BIT_CNT_WIDTH:0]     nbits_q, nbits_d;
  logic [RX_BITS_WIDTH-1:0]   rx_bits_q, rx_bits_d;
  logic [BIT_CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                       hop_err_q, hop_err_d;
  logic [15:0]                symb_q, symb_d;
  logic [SigW-1:0]            sig_q, sig_d;
  logic                       last_q, last_d;  // all NSIG samples accepted, draining pipeline
  logic                       last_bit;

  assign last_bit = (({1'b0, cnt_q} + (BIT_CNT_WIDTH + 1)'(1)) == nbits_q);

  always_comb begin
    state_d    = state_q;
    nbits_d    = nbits_q;
    rx_bits_d  = rx_bits_q;
    cnt_d      = cnt_q;
    hop_err_d  = hop_err_q;
    symb_d     = symb_q;
    sig_d      = sig_q;
    last_d     = last_q;
    accept     = 1'b0;
    acc_clr    = 1'b0;
    bit_valid  = 1'b0;
    bit_out    = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rx_trig) begin
          nbits_d   = (rx_nbits == '0 || rx_nbits > NbitsMax) ? NbitsMax : rx_nbits;
          rx_bits_d = '0;
          cnt_d     = '0;
          hop_err_d = 1'b0;
          state_d   = StWaitHop;
        end
      end
      StWaitHop: begin
        if (hop_edge_q) begin
          sig_d   = '0;
          symb_d  = '0;
          last_d  = 1'b0;
          acc_clr = 1'b1;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (hop_edge_q) begin
          // A partially (or fully, still draining) integrated symbol is discarded.
          if (sig_q != '0 || last_q) hop_err_d = 1'b1;
          sig_d   = '0;
          symb_d  = '0;
          last_d  = 1'b0;
          acc_clr = 1'b1;
        end else if (last_q) begin
          // Final product is folded into acc at this edge.
          if (acc_vld) state_d = StDecide;
        end else if (rx_valid) begin
          accept = 1'b1;
          if (sig_q == SigLast) begin
            sig_d  = '0;
            last_d = 1'b1;
          end else begin
            sig_d = sig_q + SigW'(1);
          end
        end
      end
      StDecide: begin
        bit_valid         = 1'b1;
        bit_out           = acc_nonneg;
        rx_bits_d[cnt_q]  = acc_nonneg;
        cnt_d             = cnt_q + BIT_CNT_WIDTH'(1);
        acc_clr           = 1'b1;
        last_d            = 1'b0;
        sig_d             = '0;
        if (last_bit) begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end else if (hop_edge_q) begin
          symb_d  = '0;
          state_d = StAccum;
        end else if (symb_q == SymbLast) begin
          state_d = StWaitHop;
        end else begin
          symb_d  = symb_q + 16'd1;
          state_d = StAccum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      nbits_q   <= '0;
      rx_bits_q <= '0;
      cnt_q     <= '0;
      hop_err_q <= 1'b0;
      symb_q    <= '0;
      sig_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nbits_q   <= nbits_d;
      rx_bits_q <= rx_bits_d;
      cnt_q     <= cnt_d;
      hop_err_q <= hop_err_d;
      symb_q    <= symb_d;
      sig_q     <= sig_d;
      last_q    <= last_d;
    end
  end

  assign rx_bits      = rx_bits_q;
  assign nrx_bits_cnt = cnt_q;
  assign busy         = (state_q != StIdle);
  assign hop_err      = hop_err_q;
  assign symbN        = symb_q;
  assign sigN         = sig_q;

endmodule

// File: tb/tb_mrx_ctrl.sv
module tb_mrx_ctrl;

  localparam int NSIG = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  irx, qrx, cos_ref, sin_ref;
  logic         rx_valid, hop_clk, rx_trig;
  logic [7:0]   rx_nbits;
  logic [127:0] rx_bits;
  logic [6:0]   nrx_bits_cnt;
  logic         bit_valid, bit_out, frame_done, busy, hop_err;
  logic [15:0]  symbN;
  logic [2:0]   sigN;

  always #5 clk = ~clk;

  mrx_ctrl #(
    .DATA_WIDTH    (16),
    .NSIG          (NSIG),
    .NSYMB         (4),
    .ACC_WIDTH     (48),
    .RX_BITS_WIDTH (128),
    .BIT_CNT_WIDTH (7)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .irx          (irx),
    .qrx          (qrx),
    .rx_valid     (rx_valid),
    .cos_ref      (cos_ref),
    .sin_ref      (sin_ref),
    .hop_clk      (hop_clk),
    .rx_trig      (rx_trig),
    .rx_nbits     (rx_nbits),
    .rx_bits      (rx_bits),
    .nrx_bits_cnt (nrx_bits_cnt),
    .bit_valid    (bit_valid),
    .bit_out      (bit_out),
    .frame_done   (frame_done),
    .busy         (busy),
    .hop_err      (hop_err),
    .symbN        (symbN),
    .sigN         (sigN)
  );

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  logic [127:0] exp_vec;
  int exp_n, cyc, last_bv_cyc, bv_gap, n_bv, n_fd;

  // One clock; scoreboard pops an expected bit on every bit_valid.
  task automatic step();
    bit e;
    @(posedge clk);
    #1;
    cyc++;
    if (bit_valid === 1'b1) begin
      n_bv++;
      bv_gap      = cyc - last_bv_cyc;
      last_bv_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_bit: bit_out=%b with no bit pending (cycle %0d)", bit_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bit_out !== e) begin
          errors++;
          $display("FAIL bit_out: got %b expected %b (cycle %0d)", bit_out, e, cyc);
        end
      end
    end
    if (frame_done === 1'b1) n_fd++;
  endtask

  task automatic trig(input logic [7:0] nb);
    rx_nbits = nb;
    rx_trig  = 1'b1;
    step();
    rx_trig  = 1'b0;
    exp_vec  = '0;
    exp_n    = 0;
    n_fd     = 0;
    n_bv     = 0;
  endtask

  // Rising hop strobe; the synchronized edge lands 3 cycles later.
  task automatic hop_pulse();
    hop_clk = 1'b1;
    step(); step(); step();
    hop_clk = 1'b0;
    step();
  endtask

  // One full symbol; expected bit from the correlation sum.
  task automatic feed(input logic signed [15:0] iamp, input logic signed [15:0] qamp,
                      input bit half);
    longint s;
    bit     b;
    s = longint'(NSIG) * (longint'(iamp) + longint'(qamp)) * 64'sd16384;
    b = (s >= 0);
    exp_q.push_back(b);
    exp_vec[exp_n] = b;
    exp_n++;
    for (int k = 0; k < NSIG; k++) begin
      if (half) begin
        rx_valid = 1'b0;
        step();
      end
      irx = iamp; qrx = qamp; cos_ref = 16'h4000; sin_ref = 16'h4000;
      rx_valid = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    irx = '0; qrx = '0;
    step();
    step();
  endtask

  task automatic feed_partial(input logic signed [15:0] iamp, input int n);
    for (int k = 0; k < n; k++) begin
      irx = iamp; qrx = '0; cos_ref = 16'h4000; sin_ref = 16'h4000;
      rx_valid = 1'b1;
      step();
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    irx = '0; qrx = '0; cos_ref = '0; sin_ref = '0;
    rx_valid = 1'b0; hop_clk = 1'b0; rx_trig = 1'b0; rx_nbits = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_bits !== 128'h0 || nrx_bits_cnt !== 7'h0) begin
      errors++;
      $display("FAIL reset_frame: rx_bits=%h cnt=%0d expected 0/0", rx_bits, nrx_bits_cnt);
    end
    checks++;
    if ({bit_valid, bit_out, frame_done, busy, hop_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bit_valid, bit_out, frame_done, busy, hop_err});
    end
    checks++;
    if (symbN !== 16'h0 || sigN !== 3'h0) begin
      errors++;
      $display("FAIL reset_idx: symbN=%0d sigN=%0d expected 0/0", symbN, sigN);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_all_ones();
    trig(8'd4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_trig: got %b expected 1", busy); end
    hop_pulse();
    checks++;
    if (sigN !== 3'd0 || symbN !== 16'd0) begin
      errors++;
      $display("FAIL hop_align_idx: sigN=%0d symbN=%0d expected 0/0", sigN, symbN);
    end
    repeat (4) feed(16'sh4000, 16'sh0000, 1'b0);
    step(); step();
    checks++;
    if (rx_bits !== 128'hF || rx_bits !== exp_vec) begin
      errors++;
      $display("FAIL ones_rx_bits: got %h expected %h", rx_bits, exp_vec);
    end
    checks++;
    if (n_bv !== 4 || n_fd !== 1) begin
      errors++;
      $display("FAIL ones_pulses: bit_valid=%0d frame_done=%0d expected 4/1", n_bv, n_fd);
    end
    checks++;
    if (busy !== 1'b0 || nrx_bits_cnt !== 7'd4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ones_end: busy=%b cnt=%0d pending=%0d expected 0/4/0",
               busy, nrx_bits_cnt, exp_q.size());
    end
  endtask

  task automatic test_alternate();
    trig(8'd4);
    hop_pulse();
    feed(16'sh4000, 16'sh0000, 1'b0);
    feed(-16'sh4000, 16'sh0000, 1'b0);
    checks++;
    if (bv_gap !== 10) begin errors++; $display("FAIL alt_gap: got %0d expected 10", bv_gap); end
    feed(16'sh4000, 16'sh0000, 1'b0);
    feed(-16'sh4000, 16'sh0000, 1'b0);
    step();
    checks++;
    if (rx_bits !== 128'h5 || rx_bits !== exp_vec || n_fd !== 1) begin
      errors++;
      $display("FAIL alt_rx_bits: got %h fd=%0d expected %h fd=1", rx_bits, n_fd, exp_vec);
    end
  endtask

  task automatic test_two_hops();
    trig(8'd8);
    hop_pulse();
    feed(16'sh0000, 16'sh4000, 1'b0);
    feed(16'sh0000, -16'sh4000, 1'b0);
    feed(16'sh2000, -16'sh3000, 1'b0);
    feed(-16'sh1000, 16'sh1800, 1'b0);
    // Dwell exhausted: samples must be ignored until the next hop edge.
    for (int k = 0; k < 20; k++) begin
      irx = 16'h4000; cos_ref = 16'h4000; rx_valid = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    checks++;
    if (n_bv !== 4 || nrx_bits_cnt !== 7'd4 || symbN !== 16'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hop_wait: bits=%0d cnt=%0d symbN=%0d busy=%b expected 4/4/3/1",
               n_bv, nrx_bits_cnt, symbN, busy);
    end
    hop_pulse();
    feed(16'sh4000, 16'sh0000, 1'b0);
    feed(16'sh0000, 16'sh4000, 1'b0);
    feed(-16'sh4000, 16'sh0000, 1'b0);
    feed(16'sh3000, -16'sh1000, 1'b0);
    step();
    checks++;
    if (rx_bits !== exp_vec || nrx_bits_cnt !== 7'd8 || n_fd !== 1) begin
      errors++;
      $display("FAIL two_hop_end: rx_bits=%h cnt=%0d fd=%0d expected %h/8/1",
               rx_bits, nrx_bits_cnt, n_fd, exp_vec);
    end
  endtask

  task automatic test_hop_err();
    trig(8'd1);
    hop_pulse();
    feed_partial(16'sh4000, 3);
    checks++;
    if (sigN !== 3'd3) begin errors++; $display("FAIL partial_sig: got %0d expected 3", sigN); end
    hop_pulse();
    checks++;
    if (hop_err !== 1'b1 || sigN !== 3'd0 || n_bv !== 0) begin
      errors++;
      $display("FAIL hop_err_set: hop_err=%b sigN=%0d bits=%0d expected 1/0/0",
               hop_err, sigN, n_bv);
    end
    feed(-16'sh1000, 16'sh0000, 1'b0);
    step();
    checks++;
    if (rx_bits !== exp_vec || nrx_bits_cnt !== 7'd1 || n_fd !== 1 || hop_err !== 1'b1) begin
      errors++;
      $display("FAIL hop_err_fresh: rx_bits=%h cnt=%0d fd=%0d hop_err=%b expected %h/1/1/1",
               rx_bits, nrx_bits_cnt, n_fd, hop_err, exp_vec);
    end
  endtask

  task automatic test_half_rate();
    trig(8'd4);
    checks++;
    if (hop_err !== 1'b0) begin errors++; $display("FAIL hop_err_clear: got %b expected 0", hop_err); end
    hop_pulse();
    feed(16'sh4000, 16'sh0000, 1'b0);
    feed(-16'sh4000, 16'sh0000, 1'b0);
    feed(16'sh4000, 16'sh0000, 1'b1);
    checks++;
    if (bv_gap !== 18) begin errors++; $display("FAIL half_gap: got %0d expected 18", bv_gap); end
    rx_nbits = 8'd1;
    rx_trig  = 1'b1;
    step();
    rx_trig  = 1'b0;
    feed(16'sh4000, 16'sh0000, 1'b0);
    step();
    checks++;
    if (rx_bits !== exp_vec || nrx_bits_cnt !== 7'd4 || n_fd !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_trig: rx_bits=%h cnt=%0d fd=%0d busy=%b expected %h/4/1/0",
               rx_bits, nrx_bits_cnt, n_fd, busy, exp_vec);
    end
  endtask

  task automatic test_reset_mid();
    trig(8'd4);
    hop_pulse();
    feed(16'sh4000, 16'sh0000, 1'b0);
    feed_partial(16'sh4000, 4);
    checks++;
    if (sigN !== 3'd4 || rx_bits !== 128'h1) begin
      errors++;
      $display("FAIL pre_reset: sigN=%0d rx_bits=%h expected 4/1", sigN, rx_bits);
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || sigN !== 3'd0 || rx_bits !== 128'h0 || nrx_bits_cnt !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b sigN=%0d rx_bits=%h cnt=%0d expected 0/0/0/0",
               busy, sigN, rx_bits, nrx_bits_cnt);
    end
    #1;
    reset_n = 1'b1;
    step();
    trig(8'd2);
    hop_pulse();
    feed(-16'sh4000, 16'sh0000, 1'b0);
    feed(16'sh4000, 16'sh0000, 1'b0);
    step();
    checks++;
    if (rx_bits !== 128'h2 || rx_bits !== exp_vec || nrx_bits_cnt !== 7'd2 || n_fd !== 1) begin
      errors++;
      $display("FAIL after_reset: rx_bits=%h cnt=%0d fd=%0d expected 2/2/1",
               rx_bits, nrx_bits_cnt, n_fd);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_bits: %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    cyc = 0; last_bv_cyc = 0; bv_gap = 0; n_bv = 0; n_fd = 0; exp_n = 0; exp_vec = '0;
    test_reset();
    test_all_ones();
    test_alternate();
    test_two_hops();
    test_hop_err();
    test_half_rate();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrx_ctrl.md
Name: mrx_ctrl

Overview:
- Receive-side counterpart of the multi-tone transmit controller. Recovers the transmitted bit frame from baseband I/Q.
- Per bit: coherent BPSK correlation against the local NCO reference (sin/cos), integrated over NSIG samples per symbol, hop-aligned to the hop_clk strobe arriving on front-panel GPIO.
- Decided bits are written LSB-first into a 128-bit rx_bits register, consumed by host registers and the ANC loop.

Parameters:
- DATA_WIDTH, 16, width of I/Q samples and reference sin/cos (signed).
- NSIG, 512, valid samples integrated per symbol (bit).
- NSYMB, 4, symbols per hop dwell.
- ACC_WIDTH, 48, signed accumulator width; must be >= 2*DATA_WIDTH+1+clog2(NSIG).
- RX_BITS_WIDTH, 128, frame register width.
- BIT_CNT_WIDTH, 7, bit index width (clog2 RX_BITS_WIDTH).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- irx, qrx  in  DATA_WIDTH  signed received baseband.
- rx_valid  in  1  sample qualifier.
- cos_ref, sin_ref  in  DATA_WIDTH  signed local NCO outputs, sample-aligned with irx/qrx.
- hop_clk  in  1  hop strobe from fp_gpio_in, asynchronous to clk.
- rx_trig  in  1  single-cycle frame start.
- rx_nbits  in  BIT_CNT_WIDTH+1  frame length 1..128; 0 means 128. Sampled on rx_trig.
- rx_bits  out  RX_BITS_WIDTH  decided bits, bit i = i-th received.
- nrx_bits_cnt  out  BIT_CNT_WIDTH  index of next bit to write.
- bit_valid  out  1  one-cycle pulse per decided bit.
- bit_out  out  1  decided bit, valid with bit_valid.
- frame_done  out  1  one-cycle pulse after the last bit.
- busy  out  1  high from rx_trig until frame_done.
- hop_err  out  1  sticky; hop edge arrived mid-symbol. Cleared on rx_trig.
- symbN  out  16  symbol index within the current hop.
- sigN  out  clog2(NSIG)  sample index within the current symbol.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulator 0, hop synchronizer flops 0.
- hop_clk: 2-flop synchronizer, then a registered rising-edge detect. An edge is seen 3 cycles after the input rises.
- MAC: p = irx*cos_ref + qrx*sin_ref, signed, 2*DATA_WIDTH+1 bits. p is registered only when rx_valid is high (stage 1). The accumulator adds the sign-extended p when the stage-1 valid flag is set (stage 2). No saturation; width is guaranteed by the parameter rule.
- FSM states:
  - IDLE: wait for rx_trig. On rx_trig, latch rx_nbits, clear rx_bits, count and hop_err, set busy, go to WAIT_HOP.
  - WAIT_HOP: on hop edge, clear sigN, symbN and the accumulator, go to ACCUM.
  - ACCUM: sigN increments per accepted sample. Once NSIG samples have been accumulated, go to DECIDE.
  - DECIDE (1 cycle):
    - Decision: bit = ~acc[MSB], i.e. acc >= 0 gives 1. Set rx_bits[cnt] = bit, assert bit_valid/bit_out, increment cnt, clear the accumulator.
    - If this was the last bit: frame_done pulse, busy low, go to IDLE.
    - Else if symbN == NSYMB-1: go to WAIT_HOP.
    - Else: symbN++, go to ACCUM.
- Latency: bit_valid is asserted 2 cycles after the cycle accepting the NSIG-th valid sample.
- rx_valid low: pipeline holds; sigN does not advance.
- Hop edge in ACCUM with sigN != 0: discard the partial accumulator, set hop_err, restart at symbol 0, sigN 0. No bit is emitted.
- Hop edge in ACCUM with sigN == 0, or in DECIDE: restarts hop alignment (symbN=0). It is not an error. In DECIDE the bit is still emitted.
- rx_trig while busy: ignored.
- cnt wrap: a 128-bit frame ends with cnt wrapping to 0; frame_done fires.
- reset_n low mid-frame: everything returns to reset values immediately. rx_bits contents are lost.

Decomposition:
- Package mrx_pkg holds the FSM state enum (IDLE, WAIT_HOP, ACCUM, DECIDE), the clog2 helper, and the ACC_WIDTH check constant.
- One sub-module, mrx_sym_acc: registered MAC plus accumulator with clear/enable, outputting acc and the stage-valid flag. The FSM, counters and frame register stay in mrx_ctrl.

Test Plan:
- NSIG=8, NSYMB=4, rx_nbits=4; irx=cos_ref=16'h4000, q=0; hop edge after trig -> four bit_valid pulses, bit_out=1, rx_bits=4'hF, frame_done once, busy drops.
- Same setup, alternate irx sign per symbol (+,-,+,-) -> rx_bits[3:0]=4'b0101, acc peaks at +/-2^31.
- rx_nbits=8, NSYMB=4 -> exactly 4 bits, then the FSM idles in WAIT_HOP with no pulses until the 2nd hop edge; the next 4 bits follow; nrx_bits_cnt ends 8.
- Hop edge after 3 of 8 samples -> hop_err=1, no bit emitted, the next bit uses a full fresh 8 samples.
- rx_valid toggled 50% -> bit_valid spacing doubles, values unchanged; rx_trig during busy is ignored.
- reset_n pulsed low mid-ACCUM -> all outputs 0 asynchronously. A new rx_trig works normally after release.
